// File: rtl/icache_refill_ctrl_pkg.sv
// Shared definitions for the instruction-cache refill path: bus widths common to
// the L1, the fetch stage and the refill controller, plus the refill FSM states.
package icache_refill_ctrl_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    // Number of address bits that select a word inside one refill line.
    function automatic int line_off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// L1 instruction-cache miss refill: fetches the aligned line one word at a time
// from next-level memory, writes each word into the L1, then pulses refill_done.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_W         = icache_refill_ctrl_pkg::ADDR_W,
    parameter int DATA_W         = icache_refill_ctrl_pkg::DATA_W,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ready,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              l1_wr_mode,
    output logic [ADDR_W-1:0] l1_wr_addr,
    output logic [DATA_W-1:0] l1_wr_data,
    output logic              refill_done,
    output logic [ADDR_W-1:0] refill_addr,
    output logic              busy
);

    localparam int               OFF_W    = line_off_w(WORDS_PER_LINE);
    localparam int               LINE_W   = ADDR_W - OFF_W;
    localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(WORDS_PER_LINE - 1);

    state_t              state;
    state_t              state_nxt;
    logic [OFF_W-1:0]    cnt;
    logic [LINE_W-1:0]   line_q;
    logic [ADDR_W-1:0]   miss_addr_q;
    logic [DATA_W-1:0]   word_q;
    logic [ADDR_W-1:0]   word_addr;

    // Concatenation rather than an adder: the word index can never carry into the line bits.
    assign word_addr = {line_q, cnt};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (miss_valid)    state_nxt = REQ;
            REQ:     if (mem_req_ready) state_nxt = WAIT;
            WAIT:    if (mem_rsp_valid) state_nxt = WRITE;
            WRITE:   state_nxt = (cnt == CNT_LAST) ? DONE : REQ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: these are a handful of flops, not a memory, so all of them take a reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            line_q      <= '0;
            miss_addr_q <= '0;
            word_q      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (miss_valid) begin
                        miss_addr_q <= miss_addr;
                        line_q      <= miss_addr[ADDR_W-1:OFF_W];
                        cnt         <= '0;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        word_q <= mem_rsp_data;
                    end
                end
                WRITE: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs depend on state and registers only; address/data read as zero outside their strobe.
    assign miss_ready    = (state == IDLE);
    assign busy          = (state != IDLE);
    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = mem_req_valid ? word_addr : '0;
    assign l1_wr_mode    = (state == WRITE);
    assign l1_wr_addr    = l1_wr_mode ? word_addr : '0;
    assign l1_wr_data    = l1_wr_mode ? word_q : '0;
    assign refill_done   = (state == DONE);
    assign refill_addr   = refill_done ? miss_addr_q : '0;

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss-refill controller sitting directly downstream of the instruction L1 cache. When the fetch path reports a read miss (ReadHit low) it fetches the whole aligned line from next-level memory over a valid/ready request channel, one word at a time. Each returned word is written into the L1 through its write port (mode=1, WriteAddress_Full, WriteValue). A one-cycle done pulse then tells fetch to replay the missed address.

## Interface
- ADDR_W, 16, address width; matches L1 address ports
- DATA_W, 16, instruction word width; matches L1 data ports
- WORDS_PER_LINE, 4, words per refill line; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- miss_valid  in  1  fetch reports an L1 read miss
- miss_addr  in  ADDR_W  missed word address
- miss_ready  out  1  controller can accept a miss (IDLE only)
- mem_req_valid  out  1  read request to next-level memory
- mem_req_addr  out  ADDR_W  requested word address
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  DATA_W  read data
- l1_wr_mode  out  1  drives L1 mode (1 = write)
- l1_wr_addr  out  ADDR_W  drives L1 WriteAddress_Full
- l1_wr_data  out  DATA_W  drives L1 WriteValue
- refill_done  out  1  one-cycle pulse, line fully written
- refill_addr  out  ADDR_W  original miss_addr, for fetch replay
- busy  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE → REQ on miss_valid && miss_ready: latch miss_addr; base = miss_addr with low log2(WORDS_PER_LINE) bits cleared; word counter cnt = 0.
  - REQ: mem_req_valid = 1, mem_req_addr = base + cnt. Go to WAIT when mem_req_ready.
  - WAIT: capture mem_rsp_data when mem_rsp_valid, then go to WRITE.
  - WRITE: l1_wr_mode = 1, l1_wr_addr = base + cnt, l1_wr_data = captured word. If cnt == WORDS_PER_LINE-1 go to DONE, else cnt+1 and go to REQ.
  - DONE: refill_done = 1, refill_addr = latched miss_addr, then IDLE.
- Request channel:
  - One outstanding request at a time.
  - Words are fetched in ascending order from base; there is no critical-word-first ordering.
- Address arithmetic:
  - base + cnt never carries out of the line. Example: miss 0xFFFF refills 0xFFFC..0xFFFF, with no wrap to 0x0000.
- Ignored inputs:
  - mem_rsp_valid outside WAIT is ignored.
  - miss_valid while busy is ignored (miss_ready = 0); fetch must hold its miss.

## Timing
- Reset values: miss_ready = 1; mem_req_valid, l1_wr_mode, refill_done, busy = 0; all address and data outputs = 0.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- mem_req_addr is held stable while mem_req_valid && !mem_req_ready.
- Per-word minimum latency, with ready already high and the response arriving the next cycle: 3 cycles (REQ, WAIT, WRITE).
- Line latency: accept in cycle 0; refill_done is high in cycle 3·WORDS_PER_LINE+1, i.e. cycle 13 for the default.
- l1_wr_mode is high for exactly one cycle per word. Address and data are valid in that same cycle, so the L1 samples on the following edge.
- Reset mid-refill:
  - Immediate return to IDLE; outputs take their reset values.
  - No refill_done is issued.
  - Already-written words stay in the L1; fetch re-issues the miss.
- Miss and mem response in the same cycle while IDLE: the miss is accepted and the response is ignored.

## Structure
- Shared package holds:
  - ADDR_W and DATA_W constants, shared with the L1 cache and fetch stage.
  - State enum: IDLE, REQ, WAIT, WRITE, DONE.
  - Line-offset-width helper, log2(WORDS_PER_LINE).
- Single flat module: one FSM, one word counter, address/data registers. No sub-module is warranted.

## Test plan
- Miss at 0x0005, memory returns 0x1110+i with ready tied high → requests and L1 writes go to 0x0004..0x0007 with data 0x1110..0x1113; refill_done in cycle 13; refill_addr = 0x0005.
- mem_req_ready held low 5 cycles on word 2 → mem_req_addr stays 0x0006 throughout; done is delayed by exactly 5 cycles.
- Miss at 0xFFFF → addresses 0xFFFC..0xFFFF, with no wrap to 0x0000.
- Second miss_valid (0x0100) held during a refill → miss_ready = 0 until IDLE; it is accepted the cycle after refill_done.
- rst_n pulsed low after 2 words → all outputs return to their reset values immediately; no refill_done; a new miss afterwards completes normally.
- Spurious mem_rsp_valid during REQ/IDLE → no L1 write occurs and counter unchanged.
